// File: rtl/sm_trace_if.sv
// rtl/sm_trace_if.sv - capture, trigger, readout and status bundle of the trace buffer
interface sm_trace_if #(
    parameter int AW = 4
);
    logic          arm;
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          trig_en;
    logic [31:0]   trig_pc;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_cycle;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_instr;
    logic [AW:0]   count;
    logic [2:0]    state;
    logic          trig_seen;
    logic [31:0]   trig_cycle;
    logic          busy;

    // Core / debug host side
    modport master (
        output arm, valid, pc, instr, trig_en, trig_pc, rd_addr,
        input  rd_cycle, rd_pc, rd_instr, count, state, trig_seen, trig_cycle, busy
    );

    // Trace buffer side
    modport slave (
        input  arm, valid, pc, instr, trig_en, trig_pc, rd_addr,
        output rd_cycle, rd_pc, rd_instr, count, state, trig_seen, trig_cycle, busy
    );
endinterface

// File: rtl/sm_trace_buffer.sv
// rtl/sm_trace_buffer.sv - circular {cycle, pc, instr} trace recorder; option macro SM_TRACE_NOP_FILTER_EN
module sm_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int POST_DEPTH = 4,
    parameter int NCYCLE     = 120
) (
    input  logic        clk,
    input  logic        rst,
    sm_trace_if.slave   trc
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAPT = 3'd1,
        S_POST = 3'd2,
        S_DONE = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_cyc;
    logic          r_trig_seen;
    logic [31:0]   r_trig_cycle;
    logic [AW-1:0] r_post_cnt;
    logic [95:0]   r_mem [DEPTH];
    logic [31:0]   r_rd_cycle;
    logic [31:0]   r_rd_pc;
    logic [31:0]   r_rd_instr;

    logic          w_active;
    logic          w_keep;
    logic          w_write;
    logic          w_trig;
    logic          w_post_last;
    logic          w_done;
    logic          w_tmo;
    logic [AW-1:0] w_phys;
    logic          w_rd_hit;

    assign w_active = (r_state == S_CAPT) || (r_state == S_POST);

`ifdef SM_TRACE_NOP_FILTER_EN
    // All-zero instruction words are nops and leave no trace
    assign w_keep = (trc.instr != 32'h0);
`else
    assign w_keep = 1'b1;
`endif

    assign w_write     = w_active && trc.valid && w_keep;
    assign w_trig      = (r_state == S_CAPT) && w_write && trc.trig_en && (trc.pc == trc.trig_pc);
    assign w_post_last = (r_state == S_POST) && w_write && (r_post_cnt == AW'(1));
    // Trigger completion beats the watchdog when both land on the same clock
    assign w_done      = (w_trig && (POST_DEPTH == 0)) || w_post_last;
    assign w_tmo       = w_active && (r_cyc == 32'(NCYCLE - 1));

    // Oldest entry sits count slots behind the write pointer; AW-bit wrap does the modulo
    assign w_phys   = r_wr_ptr - r_count[AW-1:0] + trc.rd_addr;
    assign w_rd_hit = ({1'b0, trc.rd_addr} < r_count);

    // Capture control FSM: arming, pointers, trigger/post window and watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_cyc        <= '0;
            r_trig_seen  <= 1'b0;
            r_trig_cycle <= '0;
            r_post_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (trc.arm) begin
                        r_state      <= S_CAPT;
                        r_wr_ptr     <= '0;
                        r_count      <= '0;
                        r_cyc        <= '0;
                        r_trig_seen  <= 1'b0;
                        r_trig_cycle <= '0;
                        r_post_cnt   <= '0;
                    end
                end
                S_CAPT, S_POST: begin
                    r_cyc <= r_cyc + 32'd1;
                    if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_count != (AW+1)'(DEPTH))
                            r_count <= r_count + 1'b1;
                    end
                    if (w_trig) begin
                        r_trig_seen  <= 1'b1;
                        r_trig_cycle <= r_cyc;
                        r_post_cnt   <= AW'(POST_DEPTH);
                    end else if ((r_state == S_POST) && w_write) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                    end
                    if (w_done)
                        r_state <= S_DONE;
                    else if (w_tmo)
                        r_state <= S_TMO;
                    else if (w_trig)
                        r_state <= S_POST;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Trace storage; contents survive reset and are only defined once written
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= {r_cyc, trc.pc, trc.instr};
    end

    // Registered read port; sees the pre-write value of a location written this clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cycle <= '0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
        end else if (w_rd_hit) begin
            {r_rd_cycle, r_rd_pc, r_rd_instr} <= r_mem[w_phys];
        end else begin
            r_rd_cycle <= '0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
        end
    end

    assign trc.rd_cycle   = r_rd_cycle;
    assign trc.rd_pc      = r_rd_pc;
    assign trc.rd_instr   = r_rd_instr;
    assign trc.count      = r_count;
    assign trc.state      = r_state;
    assign trc.trig_seen  = r_trig_seen;
    assign trc.trig_cycle = r_trig_cycle;
    assign trc.busy       = w_active;
endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb/tb_sm_trace_buffer.sv - self-checking bench for sm_trace_buffer
module tb_sm_trace_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [3:0]  rd_addr;

    sm_trace_if #(.AW(4)) ifa ();
    sm_trace_if #(.AW(4)) ifb ();

    assign ifa.arm = arm;     assign ifb.arm = arm;
    assign ifa.valid = valid; assign ifb.valid = valid;
    assign ifa.pc = pc;       assign ifb.pc = pc;
    assign ifa.instr = instr; assign ifb.instr = instr;
    assign ifa.trig_en = trig_en; assign ifb.trig_en = trig_en;
    assign ifa.trig_pc = trig_pc; assign ifb.trig_pc = trig_pc;
    assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

    sm_trace_buffer #(.DEPTH(16), .AW(4), .POST_DEPTH(4), .NCYCLE(120)) u_dut (
        .clk (clk), .rst (rst), .trc (ifa.slave)
    );
    sm_trace_buffer #(.DEPTH(16), .AW(4), .POST_DEPTH(0), .NCYCLE(120)) u_dut0 (
        .clk (clk), .rst (rst), .trc (ifb.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
    } rvec_t;

    typedef struct {
        string       nm;
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference model of the POST_DEPTH=4 instance
    int          m_state;
    logic [31:0] m_cyc;
    logic [95:0] m_q[$];
    int          m_post;
    logic        m_ts;
    logic [31:0] m_tc;

    function automatic logic [31:0] f_instr(input logic [31:0] p);
        return 32'h1000_0000 | p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clock();
        logic wr;
        int   ns;
        if (rst) begin
            m_state = 0; m_cyc = 0; m_q.delete(); m_ts = 0; m_tc = 0; m_post = 0;
        end else if (m_state == 1 || m_state == 2) begin
            wr = valid;
`ifdef SM_TRACE_NOP_FILTER_EN
            if (instr == 32'h0) wr = 1'b0;
`endif
            ns = m_state;
            if (wr) begin
                m_q.push_back({m_cyc, pc, instr});
                if (m_q.size() > 16) m_q.delete(0);
            end
            if (m_state == 1 && wr && trig_en && pc == trig_pc) begin
                m_ts = 1; m_tc = m_cyc; m_post = 4; ns = 2;
            end else if (m_state == 2 && wr) begin
                m_post--;
                if (m_post == 0) ns = 3;
            end
            if (m_cyc == 32'd119 && ns != 3) ns = 4;
            m_cyc = m_cyc + 1;
            m_state = ns;
        end else if (arm) begin
            m_state = 1; m_cyc = 0; m_q.delete(); m_ts = 0; m_tc = 0;
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] p);
        valid = 1'b1; pc = p; instr = f_instr(p);
        step();
        valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " state"}, 32'(ifa.state), m_state);
        chk({nm, " count"}, 32'(ifa.count), m_q.size());
        chk({nm, " trig_seen"}, 32'(ifa.trig_seen), 32'(m_ts));
        chk({nm, " trig_cycle"}, ifa.trig_cycle, m_tc);
    endtask

    // Scoreboarded read: expectation is queued when rd_addr is driven, popped when data appears
    task automatic rd(input logic [3:0] a, input string nm);
        exp_t e;
        int   i;
        i = int'(a);
        e.nm = nm;
        if (i < m_q.size()) begin
            e.cyc = m_q[i][95:64]; e.pc = m_q[i][63:32]; e.instr = m_q[i][31:0];
        end else begin
            e.cyc = '0; e.pc = '0; e.instr = '0;
        end
        sb.push_back(e);
        rd_addr = a;
        step();
        e = sb.pop_front();
        chk({e.nm, " rd_cycle"}, ifa.rd_cycle, e.cyc);
        chk({e.nm, " rd_pc"}, ifa.rd_pc, e.pc);
        chk({e.nm, " rd_instr"}, ifa.rd_instr, e.instr);
    endtask

    task automatic run_table(input rvec_t t[], input string nm);
        exp_t e;
        foreach (t[i]) begin
            e.nm = $sformatf("%s[%0d]", nm, i);
            e.cyc = t[i].cyc; e.pc = t[i].pc; e.instr = t[i].instr;
            sb.push_back(e);
            rd_addr = t[i].addr;
            step();
            e = sb.pop_front();
            chk({e.nm, " rd_cycle"}, ifa.rd_cycle, e.cyc);
            chk({e.nm, " rd_pc"}, ifa.rd_pc, e.pc);
            chk({e.nm, " rd_instr"}, ifa.rd_instr, e.instr);
        end
    endtask

    initial begin
        rvec_t t_fill[];
        rvec_t t_wrap[];
        int    n;
        int    seq[6];

        t_fill = new[4];
        t_fill[0] = '{4'd3,  32'd3, 32'd3, 32'h1000_0003};
        t_fill[1] = '{4'd12, 32'd0, 32'd0, 32'h0};
        t_fill[2] = '{4'd0,  32'd0, 32'd0, 32'h1000_0000};
        t_fill[3] = '{4'd9,  32'd9, 32'd9, 32'h1000_0009};
        t_wrap = new[3];
        t_wrap[0] = '{4'd0,  32'd4,  32'd4,  32'h1000_0004};
        t_wrap[1] = '{4'd15, 32'd19, 32'd19, 32'h1000_0013};
        t_wrap[2] = '{4'd8,  32'd12, 32'd12, 32'h1000_000c};
        seq = '{5, 7, 7, 3, 7, 9};

        rst = 1'b1; arm = 1'b0; valid = 1'b0; pc = '0; instr = '0;
        trig_en = 1'b0; trig_pc = '0; rd_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset state", 32'(ifa.state), 32'd0);
        chk("reset count", 32'(ifa.count), 32'd0);
        chk("reset busy", 32'(ifa.busy), 32'd0);
        chk("reset rd_pc", ifa.rd_pc, 32'd0);

        // Idle: valid traffic without arm records nothing
        for (int k = 0; k < 10; k++) cap(k);
        chk("idle state", 32'(ifa.state), 32'd0);
        chk("idle count", 32'(ifa.count), 32'd0);
        rd(4'd0, "idle rd0");

        // Fill without wrap
        do_arm();
        chk("armed state", 32'(ifa.state), 32'd1);
        chk("armed busy", 32'(ifa.busy), 32'd1);
        for (int k = 0; k < 10; k++) cap(k);
        chk("fill count", 32'(ifa.count), 32'd10);
        run_table(t_fill, "fill");
        chk_model("fill");

        // Reset mid-capture
        do_rst();
        chk("midrst state", 32'(ifa.state), 32'd0);
        chk("midrst count", 32'(ifa.count), 32'd0);
        chk("midrst rd_pc", ifa.rd_pc, 32'd0);

        // Wrap, and arm ignored while capturing
        do_arm();
        for (int k = 0; k < 20; k++) cap(k);
        do_arm();
        chk("wrap state", 32'(ifa.state), 32'd1);
        chk("wrap count", 32'(ifa.count), 32'd16);
        run_table(t_wrap, "wrap");
        for (int k = 0; k < 16; k++) rd(4'(k), $sformatf("wrap all%0d", k));
        do_rst();

        // Trigger with post window
        trig_en = 1'b1; trig_pc = 32'd7;
        do_arm();
        for (int k = 0; k < 16; k++) cap(k);
        chk("trig state", 32'(ifa.state), 32'd3);
        chk("trig seen", 32'(ifa.trig_seen), 32'd1);
        chk("trig cycle", ifa.trig_cycle, 32'd7);
        chk("trig count", 32'(ifa.count), 32'd12);
        chk("trig busy", 32'(ifa.busy), 32'd0);
        rd(4'd11, "trig rd11");
        chk("trig rd11 pc", ifa.rd_pc, 32'd11);
        rd(4'd12, "trig rd12");
        chk_model("trig");

        // Restart from DONE; repeated matches inside the post window are ignored
        do_arm();
        chk("rearm count", 32'(ifa.count), 32'd0);
        for (int k = 0; k < 6; k++) cap(seq[k]);
        chk("post state", 32'(ifa.state), 32'd3);
        chk("post trig_cycle", ifa.trig_cycle, 32'd1);
        chk("post count", 32'(ifa.count), 32'd6);
        for (int k = 0; k < 7; k++) rd(4'(k), $sformatf("post rd%0d", k));
        trig_en = 1'b0;
        do_rst();

        // Watchdog with valid on alternate clocks
        do_arm();
        n = 0;
        while (ifa.state != 3'd4 && n < 200) begin
            valid = n[0]; pc = n; instr = f_instr(n);
            step();
            n++;
        end
        valid = 1'b0;
        chk("wdog clocks", n, 32'd120);
        chk("wdog state", 32'(ifa.state), 32'd4);
        chk("wdog count", 32'(ifa.count), 32'd16);
        rd(4'd15, "wdog newest");
        chk("wdog newest cyc", ifa.rd_cycle, 32'd119);
        chk_model("wdog");
        do_arm();
        chk("wdog rearm state", 32'(ifa.state), 32'd1);
        chk("wdog rearm count", 32'(ifa.count), 32'd0);
        do_rst();

        // Trigger on the last watchdog clock
        trig_en = 1'b1; trig_pc = 32'd119;
        do_arm();
        for (int k = 0; k < 120; k++) cap(k);
        chk("same-clk pd0 state", 32'(ifb.state), 32'd3);
        chk("same-clk pd0 trig_cycle", ifb.trig_cycle, 32'd119);
        chk("same-clk pd0 count", 32'(ifb.count), 32'd16);
        chk("same-clk pd4 state", 32'(ifa.state), 32'd4);
        chk_model("same-clk pd4");
        trig_en = 1'b0;
        do_rst();

        // Nop handling
        do_arm();
        for (int k = 0; k < 6; k++) begin
            valid = 1'b1; pc = k;
            instr = (k == 2 || k == 4) ? 32'h0 : f_instr(k);
            step();
        end
        valid = 1'b0;
`ifdef SM_TRACE_NOP_FILTER_EN
        chk("nop count", 32'(ifa.count), 32'd4);
        rd(4'd2, "nop rd2");
        chk("nop rd2 cyc", ifa.rd_cycle, 32'd3);
`else
        chk("nop count", 32'(ifa.count), 32'd6);
        rd(4'd2, "nop rd2");
        chk("nop rd2 cyc", ifa.rd_cycle, 32'd2);
`endif
        chk_model("nop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
